// File: rtl/pci_arb_pkg.sv
// Shared types and constants for the PCI bus arbiter.
package pci_arb_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        GRANT      = 2'd1,
        BUSY       = 2'd2,
        TURNAROUND = 2'd3
    } state_t;

    localparam int N_DEV_DEFAULT       = 4;
    localparam int GNT_TIMEOUT_DEFAULT = 16;

    // Asserted level of every active-low bus signal.
    localparam logic NEG = 1'b0;

endpackage

// File: rtl/pci_bus_arbiter_rr_pick.sv
// Combinational round-robin picker: first active request after LAST, wrapping.
module rr_pick #(
    parameter int N_DEV = 4,
    parameter int IDX_W = 2
) (
    input  logic [N_DEV-1:0] req,
    input  logic [IDX_W-1:0] last,
    output logic [IDX_W-1:0] winner,
    output logic             any_req
);

    logic [IDX_W-1:0] idx;

    always_comb begin
        winner  = '0;
        any_req = 1'b0;
        idx     = '0;
        for (int i = 1; i <= N_DEV; i++) begin
            idx = IDX_W'((int'(last) + i) % N_DEV);
            if (!any_req && req[idx]) begin
                any_req = 1'b1;
                winner  = idx;
            end
        end
    end

endmodule

// File: rtl/pci_bus_arbiter.sv
// Central PCI bus arbiter: round-robin grants, bus-ownership tracking,
// revocation of unused grants and detection of unowned transactions.
module pci_bus_arbiter
    import pci_arb_pkg::*;
#(
    parameter int N_DEV       = N_DEV_DEFAULT,
    parameter int IDX_W       = 2,
    parameter int GNT_TIMEOUT = GNT_TIMEOUT_DEFAULT,
    parameter int TMR_W       = 5
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [N_DEV-1:0] REQ,
    output logic [N_DEV-1:0] GNT,
    input  logic             FRAME,
    input  logic             IRDY,
    output logic [IDX_W-1:0] OWNER,
    output logic             OWNER_VALID,
    output logic             TIMEOUT,
    output logic             PROT_ERR
);

    state_t           state_q, state_d;
    logic [N_DEV-1:0] gnt_q, gnt_d;
    logic [IDX_W-1:0] owner_q, owner_d;
    logic [IDX_W-1:0] last_q, last_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic             owner_valid_q, owner_valid_d;
    logic             timeout_q, timeout_d;
    logic             prot_err_q, prot_err_d;

    logic [IDX_W-1:0] winner;
    logic             any_req;
    logic             frame_low;
    logic             bus_idle;

    assign frame_low = (FRAME == NEG);
    assign bus_idle  = (FRAME != NEG) && (IRDY != NEG);

    rr_pick #(
        .N_DEV(N_DEV),
        .IDX_W(IDX_W)
    ) u_rr_pick (
        .req    (~REQ),
        .last   (last_q),
        .winner (winner),
        .any_req(any_req)
    );

    always_ff @(posedge CLK) begin
        if (RST == NEG) begin
            state_q       <= IDLE;
            gnt_q         <= '1;
            owner_q       <= '0;
            last_q        <= IDX_W'(N_DEV - 1);
            timer_q       <= '0;
            owner_valid_q <= 1'b0;
            timeout_q     <= 1'b0;
            prot_err_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            gnt_q         <= gnt_d;
            owner_q       <= owner_d;
            last_q        <= last_d;
            timer_q       <= timer_d;
            owner_valid_q <= owner_valid_d;
            timeout_q     <= timeout_d;
            prot_err_q    <= prot_err_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        gnt_d         = '1;
        owner_d       = owner_q;
        last_d        = last_q;
        timer_d       = timer_q;
        owner_valid_d = owner_valid_q;
        timeout_d     = 1'b0;
        prot_err_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (frame_low) begin
                    state_d       = BUSY;
                    prot_err_d    = 1'b1;
                    owner_valid_d = 1'b0;
                end else if (any_req) begin
                    state_d       = GRANT;
                    gnt_d         = ~(N_DEV'(1) << winner);
                    owner_d       = winner;
                    owner_valid_d = 1'b1;
                    timer_d       = '0;
                end
            end
            GRANT: begin
                if (frame_low) begin
                    state_d = BUSY;
                    last_d  = owner_q;
                end else if (REQ[owner_q] != NEG) begin
                    state_d       = IDLE;
                    owner_valid_d = 1'b0;
                end else if (bus_idle && timer_q == TMR_W'(GNT_TIMEOUT - 1)) begin
                    state_d       = IDLE;
                    owner_valid_d = 1'b0;
                    last_d        = owner_q;
                    timeout_d     = 1'b1;
                end else begin
                    gnt_d = gnt_q;
                    // Timer only counts idle-bus cycles and saturates rather than wrapping.
                    if (bus_idle && timer_q != {TMR_W{1'b1}}) begin
                        timer_d = timer_q + TMR_W'(1);
                    end
                end
            end
            BUSY: begin
                if (bus_idle) begin
                    state_d       = TURNAROUND;
                    owner_valid_d = 1'b0;
                end
            end
            TURNAROUND: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign GNT         = gnt_q;
    assign OWNER       = owner_q;
    assign OWNER_VALID = owner_valid_q;
    assign TIMEOUT     = timeout_q;
    assign PROT_ERR    = prot_err_q;

endmodule

// File: tb/tb_pci_bus_arbiter.sv
// Scoreboard bench for pci_bus_arbiter: stimulus pushes hand-computed
// expectations per cycle, a monitor pops and compares after each edge.
module tb_pci_bus_arbiter;

    logic       CLK;
    logic       RST;
    logic [3:0] REQ;
    logic [3:0] GNT;
    logic       FRAME;
    logic       IRDY;
    logic [1:0] OWNER;
    logic       OWNER_VALID;
    logic       TIMEOUT;
    logic       PROT_ERR;

    typedef struct {
        logic [3:0] gnt;
        logic [1:0] owner;
        logic       own_chk;
        logic       ov;
        logic       to;
        logic       pe;
        string      tag;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    pci_bus_arbiter dut (
        .CLK        (CLK),
        .RST        (RST),
        .REQ        (REQ),
        .GNT        (GNT),
        .FRAME      (FRAME),
        .IRDY       (IRDY),
        .OWNER      (OWNER),
        .OWNER_VALID(OWNER_VALID),
        .TIMEOUT    (TIMEOUT),
        .PROT_ERR   (PROT_ERR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // One cycle: drive inputs at negedge and queue the outputs expected after the next posedge.
    task automatic applyStimulus(input logic rst_v, input logic [3:0] req_v,
                                 input logic frame_v, input logic irdy_v,
                                 input logic [3:0] gnt_e, input logic [1:0] owner_e,
                                 input logic ov_e, input logic to_e, input logic pe_e,
                                 input string tag);
        exp_t e;
        @(negedge CLK);
        RST   = rst_v;
        REQ   = req_v;
        FRAME = frame_v;
        IRDY  = irdy_v;
        e.gnt     = gnt_e;
        e.owner   = owner_e;
        e.own_chk = ov_e | ~rst_v;
        e.ov      = ov_e;
        e.to      = to_e;
        e.pe      = pe_e;
        e.tag     = tag;
        sb.push_back(e);
    endtask

    task automatic checkOutput(input exp_t e);
        logic ok;
        ok = (GNT === e.gnt) && (OWNER_VALID === e.ov) && (TIMEOUT === e.to) &&
             (PROT_ERR === e.pe) && (!e.own_chk || OWNER === e.owner);
        checks++;
        if (!ok) begin
            errors++;
            $display("[TB] FAIL %s: got GNT=%b OWNER=%0d OV=%b TO=%b PE=%b, want GNT=%b OWNER=%0d OV=%b TO=%b PE=%b",
                     e.tag, GNT, OWNER, OWNER_VALID, TIMEOUT, PROT_ERR,
                     e.gnt, e.owner, e.ov, e.to, e.pe);
        end
        checks++;
        if ($countones(~GNT) > 1) begin
            errors++;
            $display("[TB] FAIL %s_onehot: got GNT=%b, want at most one bit low", e.tag, GNT);
        end
    endtask

    initial begin
        forever begin
            @(posedge CLK);
            #1;
            if (sb.size() > 0) checkOutput(sb.pop_front());
        end
    end

    initial begin
        logic [3:0] one;
        int         dev;
        one   = 4'b0001;
        RST   = 1'b0;
        REQ   = 4'b1111;
        FRAME = 1'b1;
        IRDY  = 1'b1;

        $display("[TB] reset and first grant");
        applyStimulus(0, 4'b1111, 1, 1, 4'b1111, 0, 0, 0, 0, "reset0");
        applyStimulus(0, 4'b1111, 1, 1, 4'b1111, 0, 0, 0, 0, "reset1");
        applyStimulus(1, 4'b1110, 1, 1, 4'b1110, 0, 1, 0, 0, "grant_dev0");
        applyStimulus(1, 4'b1110, 0, 1, 4'b1111, 0, 1, 0, 0, "frame_busy");
        applyStimulus(1, 4'b1111, 1, 0, 4'b1111, 0, 1, 0, 0, "busy_data");
        applyStimulus(1, 4'b1111, 1, 1, 4'b1111, 0, 0, 0, 0, "turnaround");
        applyStimulus(1, 4'b1111, 1, 1, 4'b1111, 0, 0, 0, 0, "idle");

        $display("[TB] round-robin with all requesting");
        applyStimulus(0, 4'b0000, 1, 1, 4'b1111, 0, 0, 0, 0, "reset_rr");
        for (int k = 0; k < 5; k++) begin
            dev = k % 4;
            applyStimulus(1, 4'b0000, 1, 1, ~(one << dev), 2'(dev), 1, 0, 0, "rr_grant");
            applyStimulus(1, 4'b0000, 0, 1, 4'b1111, 2'(dev), 1, 0, 0, "rr_addr");
            applyStimulus(1, 4'b0000, 0, 0, 4'b1111, 2'(dev), 1, 0, 0, "rr_data");
            applyStimulus(1, 4'b0000, 1, 0, 4'b1111, 2'(dev), 1, 0, 0, "rr_lastdata");
            applyStimulus(1, 4'b0000, 1, 1, 4'b1111, 2'(dev), 0, 0, 0, "rr_ta");
            applyStimulus(1, 4'b0000, 1, 1, 4'b1111, 2'(dev), 0, 0, 0, "rr_idle");
        end

        $display("[TB] grant timeout");
        applyStimulus(1, 4'b1011, 1, 1, 4'b1011, 2, 1, 0, 0, "to_grant");
        for (int k = 0; k < 15; k++)
            applyStimulus(1, 4'b1011, 1, 1, 4'b1011, 2, 1, 0, 0, "to_wait");
        applyStimulus(1, 4'b1011, 1, 1, 4'b1111, 2, 0, 1, 0, "to_revoke");
        applyStimulus(1, 4'b1011, 1, 1, 4'b1011, 2, 1, 0, 0, "to_regrant");
        for (int k = 0; k < 3; k++)
            applyStimulus(1, 4'b1011, 1, 0, 4'b1011, 2, 1, 0, 0, "to_irdy_hold");
        for (int k = 0; k < 15; k++)
            applyStimulus(1, 4'b1011, 1, 1, 4'b1011, 2, 1, 0, 0, "to_wait2");
        applyStimulus(1, 4'b1011, 1, 1, 4'b1111, 2, 0, 1, 0, "to_revoke2");
        applyStimulus(1, 4'b0011, 1, 1, 4'b0111, 3, 1, 0, 0, "to_next_dev3");
        applyStimulus(1, 4'b1111, 1, 1, 4'b1111, 3, 0, 0, 0, "withdraw3");

        $display("[TB] request withdrawn");
        applyStimulus(1, 4'b1101, 1, 1, 4'b1101, 1, 1, 0, 0, "grant_dev1");
        applyStimulus(1, 4'b1111, 1, 1, 4'b1111, 1, 0, 0, 0, "withdraw1");
        applyStimulus(1, 4'b1001, 1, 1, 4'b1101, 1, 1, 0, 0, "regrant_dev1");
        applyStimulus(1, 4'b1111, 1, 1, 4'b1111, 1, 0, 0, 0, "withdraw1b");

        $display("[TB] unowned transaction");
        applyStimulus(1, 4'b1111, 0, 1, 4'b1111, 0, 0, 0, 1, "prot_err");
        applyStimulus(1, 4'b1111, 0, 0, 4'b1111, 0, 0, 0, 0, "unowned_busy");
        applyStimulus(1, 4'b1111, 1, 1, 4'b1111, 0, 0, 0, 0, "prot_ta");
        applyStimulus(1, 4'b1111, 1, 1, 4'b1111, 0, 0, 0, 0, "prot_idle");
        applyStimulus(1, 4'b1001, 1, 1, 4'b1101, 1, 1, 0, 0, "post_prot_grant");
        applyStimulus(1, 4'b1111, 1, 1, 4'b1111, 1, 0, 0, 0, "withdraw1c");

        $display("[TB] reset during busy");
        applyStimulus(1, 4'b0000, 1, 1, 4'b0111, 3, 1, 0, 0, "f_grant3");
        applyStimulus(1, 4'b0000, 0, 1, 4'b1111, 3, 1, 0, 0, "f_busy");
        applyStimulus(0, 4'b0000, 0, 0, 4'b1111, 0, 0, 0, 0, "reset_busy");
        applyStimulus(1, 4'b0000, 1, 1, 4'b1110, 0, 1, 0, 0, "post_reset_grant0");

        @(posedge CLK);
        #2;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_drain: got %0d pending entries, want 0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
